shift8_rx: RTL

Serial-to-parallel receiver paired with the Shift8 shift register. Shift8 loads a parallel byte and shifts it out serially; this block samples that serial stream and reassembles WIDTH-bit words. It presents each complete word on a held output with a valid/read handshake toward the consuming logic. Bit order is selected per frame with a dir input.

---
 rtl/shift8_rx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/shift8_rx.sv
// Serial-to-parallel receiver for the Shift8 stream: assembles WIDTH-bit frames
// with per-frame bit order and hands each word over through a valid/rd handshake.
module shift8_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             dir,
  input  logic             sd,
  input  logic             rd,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             busy,
  output logic             ovr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] entryWord;
  logic [WIDTH-1:0] shiftedWord;
  logic             complete;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      count_q    <= '0;
      dir_q      <= 1'b0;
      q_q        <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      q_q        <= q_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shiftReg_d  = shiftReg_q;
    count_d     = count_q;
    dir_d       = dir_q;
    q_d         = q_q;
    valid_d     = valid_q;
    ovr_d       = ovr_q;
    complete    = 1'b0;

    // First bit of a frame uses the live dir; later bits follow the latched one.
    entryWord = '0;
    if (dir) begin
      entryWord[WIDTH-1] = sd;
    end else begin
      entryWord[0] = sd;
    end
    shiftedWord = dir_q ? {sd, shiftReg_q[WIDTH-1:1]} : {shiftReg_q[WIDTH-2:0], sd};

    case (state_q)
      IDLE: begin
        if (en && start) begin
          state_d    = SHIFT;
          shiftReg_d = entryWord;
          count_d    = CW'(1);
          dir_d      = dir;
        end
      end
      SHIFT: begin
        if (en) begin
          if (start) begin
            shiftReg_d = entryWord;
            count_d    = CW'(1);
            dir_d      = dir;
          end else if (count_q == LAST_BIT) begin
            complete   = 1'b1;
            state_d    = IDLE;
            count_d    = '0;
            shiftReg_d = '0;
          end else begin
            shiftReg_d = shiftedWord;
            count_d    = count_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A finished word is taken if the slot is free or being read this edge.
    if (complete) begin
      if (!valid_q || rd) begin
        q_d     = shiftedWord;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rd) begin
      valid_d = 1'b0;
    end
  end

  assign q     = q_q;
  assign valid = valid_q;
  assign busy  = (state_q == SHIFT);
  assign ovr   = ovr_q;

endmodule
